sr_lock_arbiter: RTL and testbench
==================================

Name: sr_lock_arbiter

Overview:
- Hardware semaphore that shares one set/reset-style ownership flag among N_REQ requesters.
- Round-robin arbiter grants the lock to one requester at a time. The owner keeps the lock until it pulses release, or until the optional hold timeout fires.
- Sits in front of shared sequential resources (flag registers, shared FF banks) to serialise access to them.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- MAX_HOLD, 16, max cycles a grant may be held when timeout feature enabled (>=2)
- IDW, $clog2(N_REQ), localparam, owner index width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  N_REQ  level request per requester
- rel  input  N_REQ  release pulse per requester
- gnt  output  N_REQ  one-hot grant, registered
- owner  output  IDW  index of current owner, valid when busy=1
- busy  output  1  lock held
- err_rel  output  1  one-cycle pulse: release from a non-owner, or release while idle
- timeout  output  1  one-cycle pulse: forced release (tied 0 when feature absent)

Behaviour:
- Reset (reset=1 at posedge) clears gnt, owner, busy, err_rel, timeout and the hold counter, and sets the RR pointer to 0.
- Reset mid-grant drops the lock immediately, with no timeout pulse.
- FSM states:
  - IDLE: busy=0, gnt=0.
  - HELD: busy=1, gnt=onehot(owner).
- IDLE to HELD:
  - At a posedge with req!=0, the winner is the first set req bit searching upward from the RR pointer, wrapping N_REQ-1 to 0.
  - gnt/owner/busy are visible the cycle after req is sampled (1-cycle latency).
- HELD:
  - The grant stays asserted even if req[owner] drops; only a release ends it.
  - rel[owner]=1 at a posedge moves to IDLE, sets RR pointer = owner+1 mod N_REQ, and clears gnt the next cycle.
  - Minimum idle gap is one cycle: a new grant appears at the earliest 2 cycles after the release edge.
- Release from a non-owner, or any rel while IDLE, is ignored for state and pulses err_rel for one cycle.
- Simultaneous owner release plus non-owner release: the owner release is honoured and err_rel still pulses.
- Simultaneous req and rel from the same requester in IDLE: rel is flagged as an error; req is arbitrated normally.
- Simultaneous req and rel from the owner in HELD: the release wins. The re-request competes next IDLE cycle with the lowest RR priority.
- Pointer wrap: after owner N_REQ-1 releases, the pointer is 0.
- Non-onehot rel patterns are evaluated bitwise per the rules above.
- Outputs are registered; no combinational path exists from req/rel to any output.

Optional Feature:
- Macro: SR_LOCK_TIMEOUT_EN.
- Defined:
  - Hold counter clears on grant and increments each HELD cycle.
  - When the counter reaches MAX_HOLD-1 without a release, the arbiter goes to IDLE, pulses timeout for 1 cycle, and advances the RR pointer as for a normal release.
  - An owner release on that same edge takes priority: normal release, no timeout pulse.
- Undefined: no counter logic, timeout tied 0, and the lock is held indefinitely.

Decomposition:
- Package sr_lock_pkg holds:
  - state enum typedef {IDLE, HELD}
  - default constants (N_REQ, MAX_HOLD)
  - function rr_pick(req, ptr) returning winner index plus valid
- One sub-module, rr_priority_pick: combinational rotate / priority-encode / rotate-back, parameterised by N_REQ, instantiated once.

Test Plan:
- Reset: hold reset=1 for 2 cycles with req=4'b1111 -> gnt=0, busy=0, owner=0, err_rel=0; release reset with req=4'b0101 -> gnt=4'b0001 one cycle later.
- Round-robin fairness: req=4'b1111 held, each owner pulses rel 1 cycle after grant -> grant sequence 0,1,2,3,0, with one idle cycle between grants.
- Wrap: ptr=3, req=4'b1001 -> gnt=4'b1000; after release -> gnt=4'b0001.
- Error release: owner=2, pulse rel=4'b0001 -> err_rel=1 for 1 cycle, gnt stays 4'b0100; rel=4'b0001 in IDLE -> err_rel=1, busy=0.
- Same-edge owner release + re-request: owner=1, req=4'b0110, rel=4'b0010 -> IDLE one cycle, then gnt=4'b0100.
- Timeout (SR_LOCK_TIMEOUT_EN, MAX_HOLD=16): grant to 0 with no release -> timeout pulses at hold cycle 16, gnt=0 the next cycle; a release on cycle 16 -> no timeout pulse. Macro undefined -> grant persists for 100 cycles and timeout stays 0.

Source files
------------

// File: rtl/sr_lock_pkg.sv
// Shared types, defaults and a round-robin pick helper for the sr_lock_arbiter semaphore.
// The arbiter's optional hold timeout is enabled by defining SR_LOCK_TIMEOUT_EN.
package sr_lock_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  localparam int N_REQ_DEFAULT    = 4;
  localparam int MAX_HOLD_DEFAULT = 16;
  localparam int N_REQ_MAX        = 16;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } pick_t;

  // Winner is the first set bit at or above ptr, wrapping at n; scanned downward so the
  // smallest offset is the last (and therefore surviving) assignment.
  function automatic pick_t rr_pick(input logic [N_REQ_MAX-1:0] req,
                                    input logic [3:0]           ptr,
                                    input int                   n);
    pick_t p;
    int    idx;
    p = '0;
    for (int k = N_REQ_MAX - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = (int'(ptr) + k) % n;
        if (req[idx]) begin
          p.valid = 1'b1;
          p.idx   = 4'(idx);
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/sr_lock_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: rotate req so ptr sits at bit 0, priority-encode the
// lowest set bit, then rotate the index back into requester numbering.
module rr_priority_pick #(
  parameter  int N_REQ = 4,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [IDW-1:0]   idx,
  output logic             valid
);

  logic [N_REQ-1:0] rot;
  logic [IDW-1:0]   off;
  int               sum;

  always_comb begin
    rot   = '0;
    off   = '0;
    valid = 1'b0;
    sum   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[(i + int'(ptr)) % N_REQ];
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off   = IDW'(i);
        valid = 1'b1;
      end
    end
    sum = int'(off) + int'(ptr);
    if (sum >= N_REQ) begin
      sum = sum - N_REQ;
    end
    idx = IDW'(sum);
  end

endmodule

// File: rtl/sr_lock_arbiter.sv
// Round-robin hardware semaphore: one requester owns the lock until it releases it.
// Define SR_LOCK_TIMEOUT_EN to add a forced release after MAX_HOLD held cycles.
module sr_lock_arbiter
  import sr_lock_pkg::*;
#(
  parameter  int N_REQ    = N_REQ_DEFAULT,
  parameter  int MAX_HOLD = MAX_HOLD_DEFAULT,
  localparam int IDW      = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] rel,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   owner,
  output logic             busy,
  output logic             err_rel,
  output logic             timeout
);

  state_t           state_reg, state_next;
  logic [N_REQ-1:0] gnt_reg, gnt_next;
  logic [IDW-1:0]   owner_reg, owner_next;
  logic [IDW-1:0]   ptr_reg, ptr_next;
  logic             err_reg, err_next;
  logic             to_reg, to_next;
  logic [IDW-1:0]   pick_idx;
  logic             pick_valid;
  logic [IDW-1:0]   ptr_after;
  logic             owner_rel;
  logic             force_rel;

  rr_priority_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req),
    .ptr   (ptr_reg),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // After any release the owner drops to lowest priority.
  assign ptr_after = (owner_reg == IDW'(N_REQ - 1)) ? '0 : owner_reg + IDW'(1);
  assign owner_rel = rel[owner_reg];

`ifdef SR_LOCK_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD);
  logic [HW-1:0] hold_reg, hold_next;

  assign force_rel = (state_reg == HELD) && (hold_reg == HW'(MAX_HOLD - 1));

  always_comb begin
    hold_next = '0;
    if (state_reg == HELD && !owner_rel && !force_rel) begin
      hold_next = hold_reg + HW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_reg <= '0;
    end else begin
      hold_reg <= hold_next;
    end
  end
`else
  assign force_rel = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    owner_next = owner_reg;
    ptr_next   = ptr_reg;
    err_next   = 1'b0;
    to_next    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        err_next = |rel;
        if (pick_valid) begin
          state_next = HELD;
          owner_next = pick_idx;
          gnt_next   = N_REQ'(1) << pick_idx;
        end
      end
      HELD: begin
        err_next = |(rel & ~gnt_reg);
        if (owner_rel || force_rel) begin
          state_next = IDLE;
          gnt_next   = '0;
          ptr_next   = ptr_after;
          to_next    = !owner_rel;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      owner_reg <= '0;
      ptr_reg   <= '0;
      err_reg   <= 1'b0;
      to_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      owner_reg <= owner_next;
      ptr_reg   <= ptr_next;
      err_reg   <= err_next;
      to_reg    <= to_next;
    end
  end

  assign gnt     = gnt_reg;
  assign owner   = owner_reg;
  assign busy    = (state_reg == HELD);
  assign err_rel = err_reg;
  assign timeout = to_reg;

endmodule

// File: tb/tb_sr_lock_arbiter.sv
// Self-checking bench for sr_lock_arbiter: directed scenarios plus random traffic, all
// compared against an ownership model built from the lock's rules.
module tb_sr_lock_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 16;

  logic         clk;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] rel;
  logic [N-1:0] gnt;
  logic [1:0]   owner;
  logic         busy;
  logic         err_rel;
  logic         timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner index (-1 when free), round-robin start, cycles held so far.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_err   = 1'b0;
  bit m_to    = 1'b0;

  int seq[$];

  sr_lock_arbiter #(.N_REQ(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .rel     (rel),
    .gnt     (gnt),
    .owner   (owner),
    .busy    (busy),
    .err_rel (err_rel),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] l, input logic rs);
    bit found;
    int cand;
    if (rs) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
      m_err   = 1'b0;
      m_to    = 1'b0;
    end else if (m_owner < 0) begin
      m_err = (l != 0);
      m_to  = 1'b0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        cand = (m_ptr + k) % N;
        if (!found && r[cand]) begin
          found   = 1'b1;
          m_owner = cand;
          m_held  = 0;
          $display("[TB] grant -> requester %0d (search from %0d)", cand, m_ptr);
        end
      end
    end else begin
      m_err = ((l & ~(N'(1) << m_owner)) != 0);
      m_to  = 1'b0;
      m_held++;
      if (l[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
`ifdef SR_LOCK_TIMEOUT_EN
      else if (m_held == MAX_HOLD) begin
        m_to    = 1'b1;
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
`endif
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic rs);
    logic [N-1:0] exp_gnt;
    req   = r;
    rel   = l;
    reset = rs;
    @(posedge clk);
    model_step(r, l, rs);
    #1;
    exp_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    check_eq("gnt", 32'(gnt), 32'(exp_gnt));
    check_eq("busy", 32'(busy), 32'(m_owner >= 0));
    if (m_owner >= 0) check_eq("owner", 32'(owner), m_owner);
    check_eq("err_rel", 32'(err_rel), 32'(m_err));
    check_eq("timeout", 32'(timeout), 32'(m_to));
  endtask

  task automatic do_reset();
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 1'b1);
  endtask

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] l;
    int           pick;
    reset = 1'b1;
    req   = '0;
    rel   = '0;

    // Reset with requests pending, then first grant from pointer 0.
    step(4'b1111, 4'b0000, 1'b1);
    step(4'b1111, 4'b0000, 1'b1);
    check_eq("rst_gnt", 32'(gnt), 32'h0);
    check_eq("rst_owner", 32'(owner), 32'h0);
    step(4'b0101, 4'b0000, 1'b0);
    check_eq("rst_first_gnt", 32'(gnt), 32'b0001);

    // Fairness: every requester asking, each owner releases right after its grant.
    do_reset();
    seq.delete();
    for (int g = 0; g < 5; g++) begin
      step(4'b1111, 4'b0000, 1'b0);
      seq.push_back(m_owner);
      step(4'b1111, gnt, 1'b0);
      check_eq("rr_idle_gap", 32'(busy), 32'h0);
    end
    for (int g = 0; g < 5; g++) check_eq("rr_order", seq[g], g % N);

    // Wrap: pointer at 3 after owner 2 releases.
    do_reset();
    step(4'b0100, 4'b0000, 1'b0);
    step(4'b0000, 4'b0100, 1'b0);
    step(4'b1001, 4'b0000, 1'b0);
    check_eq("wrap_gnt3", 32'(gnt), 32'b1000);
    step(4'b1001, 4'b1000, 1'b0);
    step(4'b1001, 4'b0000, 1'b0);
    check_eq("wrap_gnt0", 32'(gnt), 32'b0001);

    // Non-owner release while held, then release while idle.
    do_reset();
    step(4'b0100, 4'b0000, 1'b0);
    step(4'b0000, 4'b0001, 1'b0);
    check_eq("err_held", 32'(err_rel), 32'h1);
    check_eq("err_keep_gnt", 32'(gnt), 32'b0100);
    step(4'b0000, 4'b0000, 1'b0);
    check_eq("err_one_cycle", 32'(err_rel), 32'h0);
    step(4'b0000, 4'b0100, 1'b0);
    step(4'b0000, 4'b0001, 1'b0);
    check_eq("err_idle", 32'(err_rel), 32'h1);
    check_eq("err_idle_busy", 32'(busy), 32'h0);

    // Owner release on the same edge as its re-request.
    do_reset();
    step(4'b0010, 4'b0000, 1'b0);
    step(4'b0110, 4'b0010, 1'b0);
    check_eq("same_edge_idle", 32'(busy), 32'h0);
    step(4'b0110, 4'b0000, 1'b0);
    check_eq("same_edge_next", 32'(gnt), 32'b0100);

`ifdef SR_LOCK_TIMEOUT_EN
    do_reset();
    step(4'b0001, 4'b0000, 1'b0);
    for (int c = 1; c < MAX_HOLD; c++) step(4'b0000, 4'b0000, 1'b0);
    check_eq("to_still_held", 32'(gnt), 32'b0001);
    step(4'b0000, 4'b0000, 1'b0);
    check_eq("to_pulse", 32'(timeout), 32'h1);
    check_eq("to_gnt_clear", 32'(gnt), 32'h0);
    step(4'b0000, 4'b0000, 1'b0);
    check_eq("to_one_cycle", 32'(timeout), 32'h0);
    do_reset();
    step(4'b0001, 4'b0000, 1'b0);
    for (int c = 1; c < MAX_HOLD; c++) step(4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0001, 1'b0);
    check_eq("to_rel_wins", 32'(timeout), 32'h0);
    check_eq("to_rel_busy", 32'(busy), 32'h0);
`else
    do_reset();
    step(4'b0001, 4'b0000, 1'b0);
    for (int c = 0; c < 100; c++) step(4'b0000, 4'b0000, 1'b0);
    check_eq("hold_forever", 32'(gnt), 32'b0001);
    check_eq("no_timeout", 32'(timeout), 32'h0);
`endif

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      r    = N'($urandom_range(0, (1 << N) - 1));
      l    = '0;
      pick = $urandom_range(0, 9);
      if (m_owner >= 0 && pick < 3) l = N'(1) << m_owner;
      else if (pick == 3) l = N'($urandom_range(0, (1 << N) - 1));
      step(r, l, ($urandom_range(0, 199) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
